// File: rtl/audio_dsp_pkg.sv
// Shared types and helpers for the audio echo datapath.
// Holds the frame FSM states, default echo/feedback shifts and the saturating clamp.
package audio_dsp_pkg;

    typedef enum logic [1:0] {StIdle, StRead, StMix, StWrite} echo_state_e;

    localparam int unsigned DefMixShift = 1;
    localparam int unsigned DefFbShift  = 2;

    // Saturating-add back end: clamps a wide signed sum to the n-bit two's complement range.
    function automatic logic signed [32:0] saturate(input logic signed [32:0] sum,
                                                    input int unsigned        n);
        logic signed [32:0] max_v;
        logic signed [32:0] min_v;
        max_v = (33'sd1 <<< (n - 1)) - 33'sd1;
        min_v = -(33'sd1 <<< (n - 1));
        if (sum > max_v) return max_v;
        if (sum < min_v) return min_v;
        return sum;
    endfunction

endpackage

// File: rtl/echo_ram.sv
// Single-port synchronous delay-line RAM with read-first behaviour.
// Kept in its own module so synthesis maps it onto block RAM.
module echo_ram #(
    parameter int unsigned W  = 32,
    parameter int unsigned AW = 12
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/audio_echo.sv
// Stereo echo: once per codec frame, mixes the recorded pair with a delayed pair
// from a circular buffer and writes an attenuated feedback pair back.
module audio_echo
    import audio_dsp_pkg::*;
#(
    parameter int unsigned N         = 16,
    parameter int unsigned AW        = 12,
    parameter int unsigned MIX_SHIFT = DefMixShift,
    parameter int unsigned FB_SHIFT  = DefFbShift
) (
    input  logic          audio_clk,
    input  logic          reset,
    input  logic          NewFrame,
    input  logic [N-1:0]  LeftRecData,
    input  logic [N-1:0]  RightRecData,
    input  logic          enable,
    input  logic [AW-1:0] delay_len,
    output logic [N-1:0]  LeftPlayData,
    output logic [N-1:0]  RightPlayData,
    output logic          out_valid,
    output logic          busy,
    output logic          overrun,
    output logic          clip
);

    echo_state_e         state_q, state_d;
    logic                nf_q;
    logic                primed_q, primed_d;
    logic [AW-1:0]       ptr_q, ptr_d;
    logic signed [N-1:0] in_l_q, in_l_d, in_r_q, in_r_d;
    logic [N-1:0]        fb_l_q, fb_l_d, fb_r_q, fb_r_d;
    logic [N-1:0]        play_l_q, play_l_d, play_r_q, play_r_d;
    logic                valid_q, valid_d, clip_q, clip_d, overrun_q, overrun_d;
    logic                frame_start, echo_on, ram_en, ram_we;
    logic [2*N-1:0]      ram_rdata;
    logic signed [N-1:0] d_l, d_r;
    logic signed [32:0]  out_l_sum, out_r_sum, fb_l_sum, fb_r_sum;
    logic signed [32:0]  out_l_sat, out_r_sat, fb_l_sat, fb_r_sat;

    echo_ram #(
        .W  (2 * N),
        .AW (AW)
    ) u_ram (
        .clk   (audio_clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ptr_q),
        .wdata ({fb_l_q, fb_r_q}),
        .rdata (ram_rdata)
    );

    assign frame_start = NewFrame & ~nf_q;
    assign echo_on     = enable && (delay_len != '0);

    // Until the pointer first wraps the buffer holds stale data, so it reads as silence.
    always_comb begin
        d_l       = primed_q ? $signed(ram_rdata[2*N-1:N]) : '0;
        d_r       = primed_q ? $signed(ram_rdata[N-1:0]) : '0;
        out_l_sum = 33'(in_l_q) + 33'(d_l >>> MIX_SHIFT);
        out_r_sum = 33'(in_r_q) + 33'(d_r >>> MIX_SHIFT);
        fb_l_sum  = 33'(in_l_q) + 33'(d_l >>> FB_SHIFT);
        fb_r_sum  = 33'(in_r_q) + 33'(d_r >>> FB_SHIFT);
        out_l_sat = saturate(out_l_sum, N);
        out_r_sat = saturate(out_r_sum, N);
        fb_l_sat  = saturate(fb_l_sum, N);
        fb_r_sat  = saturate(fb_r_sum, N);
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        primed_d  = primed_q;
        in_l_d    = in_l_q;
        in_r_d    = in_r_q;
        fb_l_d    = fb_l_q;
        fb_r_d    = fb_r_q;
        play_l_d  = play_l_q;
        play_r_d  = play_r_q;
        valid_d   = 1'b0;
        clip_d    = 1'b0;
        overrun_d = frame_start && (state_q != StIdle);
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    in_l_d  = LeftRecData;
                    in_r_d  = RightRecData;
                    ram_en  = 1'b1;
                    state_d = StRead;
                end
            end
            StRead: state_d = StMix;
            StMix: begin
                if (echo_on) begin
                    play_l_d = out_l_sat[N-1:0];
                    play_r_d = out_r_sat[N-1:0];
                    fb_l_d   = fb_l_sat[N-1:0];
                    fb_r_d   = fb_r_sat[N-1:0];
                    clip_d   = (out_l_sat != out_l_sum) || (out_r_sat != out_r_sum) ||
                               (fb_l_sat != fb_l_sum) || (fb_r_sat != fb_r_sum);
                end else begin
                    // Bypass still refreshes the buffer with the dry signal.
                    play_l_d = in_l_q;
                    play_r_d = in_r_q;
                    fb_l_d   = in_l_q;
                    fb_r_d   = in_r_q;
                end
                valid_d = 1'b1;
                state_d = StWrite;
            end
            StWrite: begin
                if (delay_len != '0) begin
                    ram_en = 1'b1;
                    ram_we = 1'b1;
                    if (ptr_q >= delay_len - AW'(1)) begin
                        ptr_d    = '0;
                        primed_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + AW'(1);
                    end
                end else begin
                    ptr_d = '0;
                end
                state_d = StIdle;
            end
        endcase
        // A reset landing mid-frame must not touch the buffer.
        if (!reset) begin
            ram_en = 1'b0;
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge audio_clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            nf_q      <= 1'b0;
            ptr_q     <= '0;
            primed_q  <= 1'b0;
            in_l_q    <= '0;
            in_r_q    <= '0;
            fb_l_q    <= '0;
            fb_r_q    <= '0;
            play_l_q  <= '0;
            play_r_q  <= '0;
            valid_q   <= 1'b0;
            clip_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            nf_q      <= NewFrame;
            ptr_q     <= ptr_d;
            primed_q  <= primed_d;
            in_l_q    <= in_l_d;
            in_r_q    <= in_r_d;
            fb_l_q    <= fb_l_d;
            fb_r_q    <= fb_r_d;
            play_l_q  <= play_l_d;
            play_r_q  <= play_r_d;
            valid_q   <= valid_d;
            clip_q    <= clip_d;
            overrun_q <= overrun_d;
        end
    end

    assign LeftPlayData  = play_l_q;
    assign RightPlayData = play_r_q;
    assign out_valid     = valid_q;
    assign clip          = clip_q;
    assign overrun       = overrun_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_audio_echo.sv
// Scoreboard bench for audio_echo: frames push expected play/clip values,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_audio_echo;

    localparam int unsigned N  = 16;
    localparam int unsigned AW = 12;

    logic          audio_clk = 1'b0;
    logic          reset = 1'b0;
    logic          NewFrame = 1'b0;
    logic          enable = 1'b0;
    logic [N-1:0]  LeftRecData = '0;
    logic [N-1:0]  RightRecData = '0;
    logic [AW-1:0] delay_len = '0;
    logic [N-1:0]  LeftPlayData, RightPlayData;
    logic          out_valid, busy, overrun, clip;

    int total = 0;
    int bad = 0;
    int ovr_cnt = 0;
    int wr_cnt = 0;
    int vld_cnt = 0;

    typedef struct packed {
        logic [N-1:0] l;
        logic [N-1:0] r;
        logic         c;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    audio_echo #(
        .N  (N),
        .AW (AW)
    ) dut (
        .audio_clk     (audio_clk),
        .reset         (reset),
        .NewFrame      (NewFrame),
        .LeftRecData   (LeftRecData),
        .RightRecData  (RightRecData),
        .enable        (enable),
        .delay_len     (delay_len),
        .LeftPlayData  (LeftPlayData),
        .RightPlayData (RightPlayData),
        .out_valid     (out_valid),
        .busy          (busy),
        .overrun       (overrun),
        .clip          (clip)
    );

    always #5 audio_clk = ~audio_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    always @(negedge audio_clk) begin
        if (overrun === 1'b1) ovr_cnt++;
        if (dut.ram_we === 1'b1) wr_cnt++;
        if (out_valid === 1'b1) begin
            vld_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious out_valid: got L=%h R=%h, expected no output",
                         LeftPlayData, RightPlayData);
            end else begin
                mon_e = exp_q.pop_front();
                check("left play", 32'(LeftPlayData), 32'(mon_e.l));
                check("right play", 32'(RightPlayData), 32'(mon_e.r));
                check("clip", 32'(clip), 32'(mon_e.c));
            end
        end
    end

    task automatic do_reset();
        @(negedge audio_clk);
        reset = 1'b0;
        NewFrame = 1'b0;
        repeat (4) @(negedge audio_clk);
        check("reset left", 32'(LeftPlayData), 32'h0);
        check("reset right", 32'(RightPlayData), 32'h0);
        check("reset flags", {28'h0, out_valid, busy, overrun, clip}, 32'h0);
        reset = 1'b1;
    endtask

    // Single-cycle NewFrame; also checks busy and the 3-cycle out_valid latency.
    task automatic frame(input logic [N-1:0] l, input logic [N-1:0] r,
                         input logic [N-1:0] el, input logic [N-1:0] er, input logic ec);
        @(negedge audio_clk);
        LeftRecData = l;
        RightRecData = r;
        NewFrame = 1'b1;
        exp_q.push_back('{l: el, r: er, c: ec});
        @(negedge audio_clk);
        NewFrame = 1'b0;
        LeftRecData = ~l;
        RightRecData = ~r;
        check("busy after start", 32'(busy), 32'h1);
        check("early out_valid", 32'(out_valid), 32'h0);
        @(negedge audio_clk);
        check("early out_valid", 32'(out_valid), 32'h0);
        @(negedge audio_clk);
        check("out_valid latency", 32'(out_valid), 32'h1);
        repeat (3) @(negedge audio_clk);
        check("idle after frame", 32'(busy), 32'h0);
    endtask

    logic [N-1:0] echo_in_l [10] = '{16'h4000, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [N-1:0] echo_in_r [10] = '{16'hC000, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [N-1:0] echo_ex_l [10] = '{16'h4000, 0, 0, 16'h2000, 0, 0, 16'h0800, 0, 0, 16'h0200};
    logic [N-1:0] echo_ex_r [10] = '{16'hC000, 0, 0, 16'hE000, 0, 0, 16'hF800, 0, 0, 16'hFE00};

    initial begin
        int w, v, o;
        // Reset and first frame, unprimed buffer reads as zero.
        enable = 1'b1;
        delay_len = 12'd3;
        do_reset();
        frame(16'h1000, 16'hF000, 16'h1000, 16'hF000, 1'b0);

        // Impulse through a 3-frame delay line.
        do_reset();
        for (int i = 0; i < 10; i++)
            frame(echo_in_l[i], echo_in_r[i], echo_ex_l[i], echo_ex_r[i], 1'b0);

        // Saturation: one-frame delay primes after the first frame.
        do_reset();
        delay_len = 12'd1;
        frame(16'h7000, 16'h8000, 16'h7000, 16'h8000, 1'b0);
        frame(16'h7000, 16'h8000, 16'h7FFF, 16'h8000, 1'b1);

        // Bypass with enable low still writes the dry pair.
        enable = 1'b0;
        w = wr_cnt;
        frame(16'h1234, 16'h5678, 16'h1234, 16'h5678, 1'b0);
        check("bypass write", 32'(wr_cnt), 32'(w + 1));
        enable = 1'b1;
        frame(16'h0000, 16'h0000, 16'h091A, 16'h2B3C, 1'b0);

        // Zero delay: no write, buffer keeps 048D/159E.
        delay_len = 12'd0;
        w = wr_cnt;
        frame(16'h1111, 16'h2222, 16'h1111, 16'h2222, 1'b0);
        check("no write at delay 0", 32'(wr_cnt), 32'(w));
        delay_len = 12'd1;
        frame(16'h0000, 16'h0000, 16'h0246, 16'h0ACF, 1'b0);

        // NewFrame held high for 10 cycles gives one frame.
        delay_len = 12'd0;
        v = vld_cnt;
        o = ovr_cnt;
        @(negedge audio_clk);
        LeftRecData = 16'h0AAA;
        RightRecData = 16'h0BBB;
        NewFrame = 1'b1;
        exp_q.push_back('{l: 16'h0AAA, r: 16'h0BBB, c: 1'b0});
        repeat (10) @(negedge audio_clk);
        NewFrame = 1'b0;
        repeat (6) @(negedge audio_clk);
        check("long NewFrame valids", 32'(vld_cnt), 32'(v + 1));
        check("long NewFrame overruns", 32'(ovr_cnt), 32'(o));

        // Second edge two cycles after the first is dropped.
        v = vld_cnt;
        @(negedge audio_clk);
        LeftRecData = 16'h0123;
        RightRecData = 16'hFEDC;
        NewFrame = 1'b1;
        exp_q.push_back('{l: 16'h0123, r: 16'hFEDC, c: 1'b0});
        @(negedge audio_clk);
        NewFrame = 1'b0;
        @(negedge audio_clk);
        NewFrame = 1'b1;
        @(negedge audio_clk);
        NewFrame = 1'b0;
        check("overrun pulse", 32'(overrun), 32'h1);
        repeat (6) @(negedge audio_clk);
        check("overrun count", 32'(ovr_cnt), 32'(o + 1));
        check("overrun valids", 32'(vld_cnt), 32'(v + 1));

        // Shrinking delay below ptr wraps on the next write.
        do_reset();
        delay_len = 12'd16;
        frame(16'h4000, 16'hC000, 16'h4000, 16'hC000, 1'b0);
        for (int i = 0; i < 9; i++) frame(16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
        delay_len = 12'd4;
        frame(16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
        frame(16'h0, 16'h0, 16'h2000, 16'hE000, 1'b0);

        // Reset while in MIX abandons the frame.
        w = wr_cnt;
        v = vld_cnt;
        @(negedge audio_clk);
        LeftRecData = 16'h7777;
        RightRecData = 16'h7777;
        NewFrame = 1'b1;
        @(negedge audio_clk);
        NewFrame = 1'b0;
        @(negedge audio_clk);
        check("in MIX before reset", 32'(busy), 32'h1);
        reset = 1'b0;
        @(negedge audio_clk);
        check("mid reset left", 32'(LeftPlayData), 32'h0);
        check("mid reset right", 32'(RightPlayData), 32'h0);
        check("mid reset flags", {28'h0, out_valid, busy, overrun, clip}, 32'h0);
        repeat (3) @(negedge audio_clk);
        reset = 1'b1;
        repeat (4) @(negedge audio_clk);
        check("mid reset writes", 32'(wr_cnt), 32'(w));
        check("mid reset valids", 32'(vld_cnt), 32'(v));

        check("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
